register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port successor of the CPU integer register file: NRD combinational read ports, two prioritised write ports, and a per-register pending scoreboard for pipeline hazard detection.
- Includes a sequential bulk-clear engine used on pipeline flush/context reset.
- Sits between decode (read/issue) and writeback (write ports) in the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of registers (power of two, >=4); AW = $clog2(NREGS) is derived locally.
- NRD, 2, number of read ports (>=1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising CLK.
- wen  in  2  write enables; bit0 = port 0, bit1 = port 1.
- wsel0  in  AW  port 0 destination register.
- wdat0  in  DATA_W  port 0 write data.
- wsel1  in  AW  port 1 destination register.
- wdat1  in  DATA_W  port 1 write data.
- rsel  in  NRD*AW  read selects; port k occupies bits [k*AW +: AW].
- rdat  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- rpend  out  NRD  pending bit of the register selected on each read port.
- iss_en  in  1  issue strobe: marks iss_sel as having an outstanding producer.
- iss_sel  in  AW  register being issued.
- clr_req  in  1  bulk-clear request.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset: all regs = 0, all pending = 0, FSM = IDLE, clr_busy = 0, clr_done = 0. Reset is synchronous only: no effect until the next CLK edge, and it overrides all other inputs that cycle.
- Register 0:
  - Always reads 0 with rpend = 0.
  - Writes and issues to it are ignored.
- Reads are combinational (0-cycle). They return the contents as of the last edge (no bypass; see optional feature). They are independent of wen, which fixes the old behaviour of zeroing reads during writes.
- Writes occur at the rising edge when the wen bit is set.
  - Both ports targeting the same register in one cycle: port 1 wins.
  - A write clears that register's pending bit.
- Issue: when iss_en is set, pending[iss_sel] is set at the edge.
  - Issue and write to the same register in the same cycle: pending ends set (the new producer wins); data is still written.
- Clear FSM states: IDLE, CLEAR, DONE; counter cnt is AW bits wide.
  - IDLE: clr_req=1 -> CLEAR with cnt=0. Normal writes and issues are accepted that cycle.
  - CLEAR: each edge sets regs[cnt] <= 0 and pending[cnt] <= 0, then cnt++. When cnt == NREGS-1 -> DONE.
  - DONE: clr_done = 1 for exactly this cycle -> IDLE.
  - clr_busy = 1 in CLEAR and DONE: NREGS+1 cycles in total, first asserted the cycle after clr_req is sampled.
  - While clr_busy: wen and iss_en are ignored (no state change); clr_req is ignored; reads still return current, partially cleared contents.
  - Reset mid-clear: FSM returns to IDLE, all regs and pending bits = 0, no clr_done pulse.
- Width rule: no arithmetic on data. cnt wraps naturally, but the FSM leaves CLEAR before the wrap.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read port whose rsel matches an active write port in the same cycle returns that write data (port 1 over port 0), with rpend = 0 for that port.
  - Bypass is suppressed while clr_busy, and never applies to register 0.
- Undefined: reads return pre-write contents; new data is visible the cycle after the edge.

Test Plan:
- Reset/r0: hold nRST=0 two edges, then write 0xDEADBEEF to r0 and r5 on port 0 -> r0 reads 0x00000000, r5 reads 0xDEADBEEF next cycle, all rpend = 0.
- Write collision: wen=2'b11, wsel0=wsel1=7, wdat0=0x11111111, wdat1=0x22222222 -> r7 = 0x22222222.
- Scoreboard: issue r3 -> rpend for rsel=3 is 1. Write r3 = 0x5 next cycle -> rpend 0, rdat 0x5. Same-cycle issue+write on r3 -> rpend stays 1.
- Bulk clear: fill r1..r31 with 0xA5A5A5A5, pulse clr_req -> clr_busy high 33 cycles, clr_done a single pulse on the 33rd, all regs 0; a wen during busy leaves no change.
- Reset mid-clear: nRST=0 at cycle 10 of CLEAR -> next cycle IDLE, clr_busy 0, clr_done never pulses, all regs 0.
- Bypass (RF_BYPASS_EN): write r9 = 0xCAFEF00D with rsel port 1 = 9 in the same cycle -> rdat port 1 = 0xCAFEF00D combinationally. Without the macro it shows the old value that cycle and the new value the next.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with a per-register
// pending scoreboard and a sequential bulk-clear engine.
//
// NRD combinational read ports, two write ports (port 1 has priority),
// an issue port that marks a register as having an outstanding producer,
// and a clear engine that zeroes one register per cycle on request.
// Register 0 is hardwired to zero and is never pending.
//
// Optional build macro RF_BYPASS_EN: when defined, a read port whose select
// matches an active write port in the same cycle returns the write data
// (port 1 over port 0) with rpend = 0. Bypass is off while the clear engine
// is busy and never applies to register 0. When undefined, reads return the
// contents as of the last clock edge.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | normal operation, writes and issues accepted
// ST_CLEAR | zeroing regs[cnt] and pending[cnt], one register per cycle
// ST_DONE  | clear finished, clr_done pulses for this single cycle

module register_file_mp #(
   parameter int  DATA_W = 32,
   parameter int  NREGS  = 32,
   parameter int  NRD    = 2,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [1:0]            wen,
   input  logic [AW-1:0]         wsel0,
   input  logic [DATA_W-1:0]     wdat0,
   input  logic [AW-1:0]         wsel1,
   input  logic [DATA_W-1:0]     wdat1,
   input  logic [NRD*AW-1:0]     rsel,
   output logic [NRD*DATA_W-1:0] rdat,
   output logic [NRD-1:0]        rpend,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_sel,
   input  logic                  clr_req,
   output logic                  clr_busy,
   output logic                  clr_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

   state_t              state;
   logic [AW-1:0]       cnt;
   logic [DATA_W-1:0]   regs [NREGS];
   logic [NREGS-1:0]    pend;

   // Clear sequencer: cnt walks every register once, busy/done are registered.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               clr_done <= 1'b0;
               if (clr_req) begin
                  state    <= ST_CLEAR;
                  cnt      <= '0;
                  clr_busy <= 1'b1;
               end
            end
            ST_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state    <= ST_DONE;
                  clr_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   // Register and scoreboard storage; port 1 is applied after port 0 so it
   // wins a collision, and issue is applied last so a new producer wins.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         pend <= '0;
      end else if (state == ST_CLEAR) begin
         regs[cnt] <= '0;
         pend[cnt] <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (wen[0] && (wsel0 != '0)) begin
            regs[wsel0] <= wdat0;
            pend[wsel0] <= 1'b0;
         end
         if (wen[1] && (wsel1 != '0)) begin
            regs[wsel1] <= wdat1;
            pend[wsel1] <= 1'b0;
         end
         if (iss_en && (iss_sel != '0)) begin
            pend[iss_sel] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]     sel;
      logic [DATA_W-1:0] rd;
      logic              rp;

      assign sel = rsel[k*AW +: AW];

      // Combinational read with register 0 forced to zero and never pending.
      always_comb begin
         rd = regs[sel];
         rp = pend[sel];
`ifdef RF_BYPASS_EN
         if (!clr_busy) begin
            if (wen[1] && (wsel1 == sel)) begin
               rd = wdat1;
               rp = 1'b0;
            end else if (wen[0] && (wsel0 == sel)) begin
               rd = wdat0;
               rp = 1'b0;
            end
         end
`else
`endif
         if (sel == '0) begin
            rd = '0;
            rp = 1'b0;
         end
      end

      assign rdat[k*DATA_W +: DATA_W] = rd;
      assign rpend[k]                 = rp;
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a reference model of the register file kept in
// plain arrays, a per-cycle compare process, and directed scenarios with
// hand-computed literal expectations.

module tb_register_file_mp;

   localparam int DATA_W = 32;
   localparam int NREGS  = 32;
   localparam int NRD    = 2;
   localparam int AW     = 5;

   logic                  CLK = 1'b0;
   logic                  nRST;
   logic [1:0]            wen;
   logic [AW-1:0]         wsel0, wsel1, iss_sel;
   logic [DATA_W-1:0]     wdat0, wdat1;
   logic [NRD*AW-1:0]     rsel;
   logic [NRD*DATA_W-1:0] rdat;
   logic [NRD-1:0]        rpend;
   logic                  iss_en, clr_req;
   logic                  clr_busy, clr_done;

   register_file_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD)) dut (
      .CLK(CLK), .nRST(nRST), .wen(wen),
      .wsel0(wsel0), .wdat0(wdat0), .wsel1(wsel1), .wdat1(wdat1),
      .rsel(rsel), .rdat(rdat), .rpend(rpend),
      .iss_en(iss_en), .iss_sel(iss_sel),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents, pending flags, and the position in a
   // clear sequence (0 = not clearing, 1..NREGS = clearing register m_clr-1,
   // NREGS+1 = the completion cycle).
   logic [DATA_W-1:0] m_regs [NREGS];
   bit                m_pend [NREGS];
   int                m_clr = 0;

   always @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_clr = 0;
      end else if (m_clr == 0) begin
         if (wen[0] && wsel0 != 0) begin
            m_regs[wsel0] = wdat0;
            m_pend[wsel0] = 1'b0;
         end
         if (wen[1] && wsel1 != 0) begin
            m_regs[wsel1] = wdat1;
            m_pend[wsel1] = 1'b0;
         end
         if (iss_en && iss_sel != 0) m_pend[iss_sel] = 1'b1;
         if (clr_req) m_clr = 1;
      end else if (m_clr <= NREGS) begin
         m_regs[m_clr-1] = '0;
         m_pend[m_clr-1] = 1'b0;
         m_clr++;
      end else begin
         m_clr = 0;
      end
   end

   task automatic exp_read(input int k, output logic [31:0] d, output logic p);
      int s;
      s = int'(rsel[k*AW +: AW]);
      d = m_regs[s];
      p = m_pend[s];
`ifdef RF_BYPASS_EN
      if (m_clr == 0) begin
         if (wen[1] && int'(wsel1) == s) begin
            d = wdat1;
            p = 1'b0;
         end else if (wen[0] && int'(wsel0) == s) begin
            d = wdat0;
            p = 1'b0;
         end
      end
`endif
      if (s == 0) begin
         d = '0;
         p = 1'b0;
      end
   endtask

   // Compare process: every cycle, mid-period.
   always @(negedge CLK) begin
      if (check_en) begin
         for (int k = 0; k < NRD; k++) begin
            logic [31:0] d;
            logic        p;
            exp_read(k, d, p);
            chk($sformatf("model_rdat%0d", k), rdat[k*DATA_W +: DATA_W], d);
            chk($sformatf("model_rpend%0d", k), 32'(rpend[k]), 32'(p));
         end
         chk("model_clr_busy", 32'(clr_busy), 32'(m_clr != 0));
         chk("model_clr_done", 32'(clr_done), 32'(m_clr == NREGS + 1));
      end
   end

   int busy_cnt = 0;
   int done_cnt = 0;
   int busy_at_done = 0;

   always @(negedge CLK) begin
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin
         done_cnt++;
         busy_at_done = busy_cnt;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_rd(input int p0, input int p1);
      rsel = {AW'(p1), AW'(p0)};
   endtask

   task automatic idle_inputs();
      wen = 2'b00; iss_en = 1'b0; clr_req = 1'b0;
   endtask

   task automatic write0(input int r, input logic [31:0] d);
      wen = 2'b01; wsel0 = AW'(r); wdat0 = d;
      tick();
      wen = 2'b00;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (clr_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      bit seen;
      nRST = 1'b0;
      wen = 2'b00; wsel0 = '0; wsel1 = '0; wdat0 = '0; wdat1 = '0;
      iss_en = 1'b0; iss_sel = '0; clr_req = 1'b0;
      set_rd(0, 0);
      tick();
      tick();
      nRST = 1'b1;
      check_en = 1'b1;

      // Reset state
      set_rd(5, 31);
      #2;
      chk("reset_rdat0", rdat[31:0], 32'h0);
      chk("reset_rdat1", rdat[63:32], 32'h0);
      chk("reset_rpend", 32'(rpend), 32'h0);
      chk("reset_busy", 32'(clr_busy), 32'h0);
      chk("reset_done", 32'(clr_done), 32'h0);

      // Register 0 ignores writes, r5 takes the data
      write0(0, 32'hDEADBEEF);
      write0(5, 32'hDEADBEEF);
      set_rd(0, 5);
      #2;
      chk("r0_reads_zero", rdat[31:0], 32'h0);
      chk("r5_written", rdat[63:32], 32'hDEADBEEF);
      chk("r0_r5_rpend", 32'(rpend), 32'h0);
      tick();

      // Write collision: port 1 wins
      wen = 2'b11; wsel0 = 5'd7; wsel1 = 5'd7;
      wdat0 = 32'h11111111; wdat1 = 32'h22222222;
      tick();
      wen = 2'b00;
      set_rd(7, 5);
      #2;
      chk("collision_r7", rdat[31:0], 32'h22222222);
      tick();

      // Two ports to different registers
      wen = 2'b11; wsel0 = 5'd10; wdat0 = 32'h0000AAAA;
      wsel1 = 5'd11; wdat1 = 32'h0000BBBB;
      tick();
      wen = 2'b00;
      set_rd(10, 11);
      #2;
      chk("dual_r10", rdat[31:0], 32'h0000AAAA);
      chk("dual_r11", rdat[63:32], 32'h0000BBBB);
      tick();

      // Scoreboard
      iss_en = 1'b1; iss_sel = 5'd3;
      tick();
      iss_en = 1'b0;
      set_rd(3, 0);
      #2;
      chk("issue_r3_pend", 32'(rpend), 32'h1);
      tick();
      write0(3, 32'h5);
      #2;
      chk("write_r3_clears_pend", 32'(rpend), 32'h0);
      chk("write_r3_data", rdat[31:0], 32'h5);
      tick();
      wen = 2'b01; wsel0 = 5'd3; wdat0 = 32'h6;
      iss_en = 1'b1; iss_sel = 5'd3;
      tick();
      idle_inputs();
      #2;
      chk("issue_write_same_pend", 32'(rpend), 32'h1);
      chk("issue_write_same_data", rdat[31:0], 32'h6);
      tick();
      iss_en = 1'b1; iss_sel = 5'd0;
      tick();
      iss_en = 1'b0;
      set_rd(0, 3);
      #2;
      chk("issue_r0_ignored", 32'(rpend), 32'h2);
      tick();

      // Same-cycle read of a register being written
      write0(9, 32'h00000099);
      iss_en = 1'b1; iss_sel = 5'd9;
      tick();
      iss_en = 1'b0;
      wen = 2'b10; wsel1 = 5'd9; wdat1 = 32'hCAFEF00D;
      set_rd(0, 9);
      #2;
`ifdef RF_BYPASS_EN
      chk("bypass_same_cycle", rdat[63:32], 32'hCAFEF00D);
      chk("bypass_rpend", 32'(rpend), 32'h0);
`else
      chk("nobypass_same_cycle", rdat[63:32], 32'h00000099);
      chk("nobypass_rpend", 32'(rpend), 32'h2);
`endif
      tick();
      wen = 2'b00;
      #2;
      chk("r9_next_cycle", rdat[63:32], 32'hCAFEF00D);
      chk("r9_next_pend", 32'(rpend), 32'h0);
      tick();

      // Bulk clear
      for (int r = 1; r < NREGS; r++) write0(r, 32'hA5A5A5A5);
      iss_en = 1'b1; iss_sel = 5'd12;
      tick();
      iss_en = 1'b0;
      set_rd(12, 31);
      #2;
      chk("fill_r12_pend", 32'(rpend), 32'h1);
      chk("fill_r31", rdat[63:32], 32'hA5A5A5A5);
      tick();
      busy_cnt = 0; done_cnt = 0; busy_at_done = 0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      #2;
      chk("clr_busy_start", 32'(clr_busy), 32'h1);
      wen = 2'b11; wsel0 = 5'd31; wdat0 = 32'h1234; wsel1 = 5'd30; wdat1 = 32'h5678;
      iss_en = 1'b1; iss_sel = 5'd29; clr_req = 1'b1;
      tick();
      tick();
      tick();
      idle_inputs();
      wait_done(seen);
      chk("clr_done_seen", 32'(seen), 32'h1);
      tick();
      chk("clr_busy_cycles", 32'(busy_cnt), 32'd33);
      chk("clr_done_pulses", 32'(done_cnt), 32'd1);
      chk("clr_done_on_last", 32'(busy_at_done), 32'd33);
      chk("clr_busy_end", 32'(clr_busy), 32'h0);
      for (int r = 0; r < NREGS; r++) begin
         set_rd(r, NREGS - 1 - r);
         #2;
         chk($sformatf("cleared_r%0d", r), rdat[31:0], 32'h0);
         chk($sformatf("cleared_pend_r%0d", r), 32'(rpend), 32'h0);
         tick();
      end
      write0(4, 32'h44);
      set_rd(4, 0);
      #2;
      chk("write_after_clear", rdat[31:0], 32'h44);
      tick();

      // Reset mid-clear
      write0(2, 32'h3C3C3C3C);
      write0(30, 32'h3C3C3C3C);
      iss_en = 1'b1; iss_sel = 5'd30;
      tick();
      iss_en = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (9) tick();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      set_rd(2, 30);
      #2;
      chk("midclr_busy", 32'(clr_busy), 32'h0);
      chk("midclr_done", 32'(clr_done), 32'h0);
      chk("midclr_r2", rdat[31:0], 32'h0);
      chk("midclr_r30", rdat[63:32], 32'h0);
      chk("midclr_pend", 32'(rpend), 32'h0);
      repeat (40) tick();
      chk("midclr_no_done", 32'(done_cnt), 32'd0);
      chk("midclr_busy_cycles", 32'(busy_cnt), 32'd10);

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
